// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared state encoding and sizing helper for sipo_deserializer
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in parallel-out word receiver; SIPO_PARITY_EN adds a trailing even-parity bit
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             serial_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             busy,
    output logic             parity_err
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign shifted = {sreg[WIDTH-2:0], serial_in};
        end else begin : g_lsb_first
            assign shifted = {serial_in, sreg[WIDTH-1:1]};
        end
    endgenerate

`ifndef SIPO_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            sreg         <= '0;
            parallel_out <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err   <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (in_valid) begin
                        sreg <= shifted;
                        // Counter saturates at the last bit instead of wrapping.
                        if (cnt == LAST_BIT) begin
`ifdef SIPO_PARITY_EN
                            state <= PARITY;
`else
                            parallel_out <= shifted;
                            out_valid    <= 1'b1;
                            busy         <= 1'b0;
                            state        <= IDLE;
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
`ifdef SIPO_PARITY_EN
                PARITY: begin
                    if (in_valid) begin
                        parallel_out <= sreg;
                        parity_err   <= (^sreg) ^ serial_in;
                        out_valid    <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
